// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - two-requester block memory arbiter (D cache, I cache)
// Optional round-robin arbitration under ARB_ROUND_ROBIN_EN; default is fixed D-over-I priority.
module mem_bus_arbiter #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_address,
    input  logic [DATA_WIDTH-1:0] d_writedata,
    output logic [DATA_WIDTH-1:0] d_readdata,
    output logic                  d_busywait,
    input  logic                  i_read,
    input  logic [ADDR_WIDTH-1:0] i_address,
    output logic [DATA_WIDTH-1:0] i_readdata,
    output logic                  i_busywait,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_writedata,
    input  logic [DATA_WIDTH-1:0] mem_readdata,
    input  logic                  mem_busywait,
    output logic [1:0]            grant
);

    typedef enum logic [1:0] {IDLE, GNT_D, GNT_I, RELEASE} state_t;

    state_t                  state;
    logic                    started;
    logic                    last;
    logic [ADDR_WIDTH-1:0]   hold_address;
    logic [DATA_WIDTH-1:0]   hold_writedata;

    logic req_d;
    logic req_i;
    logic complete;
    logic pick_d;
    logic pick_i;

    assign req_d    = d_read | d_write;
    assign req_i    = i_read;
    assign complete = started & ~mem_busywait;

`ifdef ARB_ROUND_ROBIN_EN
    // last = 1 means I was served most recently, so D gets the next tie.
    assign pick_d = req_d & (~req_i | last);
`else
    logic unused_last;
    assign unused_last = last;
    assign pick_d      = req_d;
`endif
    assign pick_i = req_i & ~pick_d;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state          <= IDLE;
            started        <= 1'b0;
            last           <= 1'b0;
            grant          <= 2'b00;
            hold_address   <= '0;
            hold_writedata <= '0;
        end else begin
            case (state)
                IDLE, RELEASE: begin
                    started <= 1'b0;
                    if (pick_d) begin
                        state <= GNT_D;
                        grant <= 2'b01;
                    end else if (pick_i) begin
                        state <= GNT_I;
                        grant <= 2'b10;
                    end else begin
                        state <= IDLE;
                        grant <= 2'b00;
                    end
                end
                GNT_D: begin
                    hold_address   <= d_address;
                    hold_writedata <= d_writedata;
                    if (mem_busywait) started <= 1'b1;
                    if (complete) begin
                        state   <= RELEASE;
                        grant   <= 2'b00;
                        started <= 1'b0;
                        last    <= 1'b0;
                    end
                end
                GNT_I: begin
                    hold_address <= i_address;
                    if (mem_busywait) started <= 1'b1;
                    if (complete) begin
                        state   <= RELEASE;
                        grant   <= 2'b00;
                        started <= 1'b0;
                        last    <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= 2'b00;
                end
            endcase
        end
    end

    // Outside a grant the memory strobes are low, so the held address/data are don't-care.
    always_comb begin
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_address   = hold_address;
        mem_writedata = hold_writedata;
        case (state)
            GNT_D: begin
                mem_write     = d_write;
                mem_read      = d_read & ~d_write;
                mem_address   = d_address;
                mem_writedata = d_writedata;
            end
            GNT_I: begin
                mem_read    = i_read;
                mem_address = i_address;
            end
            default: begin
            end
        endcase
    end

    assign d_busywait = ~RESET & req_d & ~((state == GNT_D) & complete);
    assign i_busywait = ~RESET & req_i & ~((state == GNT_I) & complete);
    assign d_readdata = mem_readdata;
    assign i_readdata = mem_readdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - scoreboard bench for mem_bus_arbiter with a block memory model
module tb_mem_bus_arbiter;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        d_read = 1'b0;
    logic        d_write = 1'b0;
    logic [5:0]  d_address = '0;
    logic [31:0] d_writedata = '0;
    logic [31:0] d_readdata;
    logic        d_busywait;
    logic        i_read = 1'b0;
    logic [5:0]  i_address = '0;
    logic [31:0] i_readdata;
    logic        i_busywait;
    logic        mem_read;
    logic        mem_write;
    logic [5:0]  mem_address;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        mem_busywait;
    logic [1:0]  grant;

    int tests = 0;
    int failed = 0;

    typedef struct {
        logic        wr;
        logic [5:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t       exp_d[$];
    exp_t       exp_i[$];
    logic [1:0] grant_log[$];

    always #5 CLK = ~CLK;

    mem_bus_arbiter #(.ADDR_WIDTH(6), .DATA_WIDTH(32)) dut (
        .CLK(CLK), .RESET(RESET),
        .d_read(d_read), .d_write(d_write), .d_address(d_address),
        .d_writedata(d_writedata), .d_readdata(d_readdata), .d_busywait(d_busywait),
        .i_read(i_read), .i_address(i_address), .i_readdata(i_readdata),
        .i_busywait(i_busywait),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
        .mem_busywait(mem_busywait), .grant(grant)
    );

    // Memory: busywait rises the cycle after a request is seen, falls 5 cycles later.
    logic [31:0] mem [64];
    logic [2:0]  m_cnt;
    logic        m_done;
    logic        m_wr;
    logic [5:0]  m_addr;
    logic [31:0] m_wdata;

    always @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            mem_busywait <= 1'b0;
            mem_readdata <= '0;
            m_cnt        <= '0;
            m_done       <= 1'b0;
            m_wr         <= 1'b0;
            m_addr       <= '0;
            m_wdata      <= '0;
            for (int k = 0; k < 64; k++) mem[k] <= 32'hA5000000 | k;
            mem[5] <= 32'hDEADBEEF;
        end else begin
            m_done <= 1'b0;
            if (mem_busywait) begin
                if (m_cnt == 0) begin
                    mem_busywait <= 1'b0;
                    m_done       <= 1'b1;
                    if (m_wr) mem[m_addr] <= m_wdata;
                    else      mem_readdata <= mem[m_addr];
                end else begin
                    m_cnt <= m_cnt - 3'd1;
                end
            end else if (!m_done && (mem_read || mem_write)) begin
                mem_busywait <= 1'b1;
                m_cnt        <= 3'd4;
                m_wr         <= mem_write;
                m_addr       <= mem_address;
                m_wdata      <= mem_writedata;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every owner completion cycle is compared against the scoreboard.
    always @(negedge CLK) begin
        exp_t e;
        if (!RESET && grant[0] && (d_read || d_write) && !d_busywait) begin
            if (exp_d.size() == 0) check("d_unexpected_completion", 1, 0);
            else begin
                e = exp_d.pop_front();
                check("d_mem_address", {26'd0, mem_address}, {26'd0, e.addr});
                if (e.wr) begin
                    check("d_mem_write", {31'd0, mem_write}, 1);
                    check("d_mem_read_low", {31'd0, mem_read}, 0);
                    check("d_mem_writedata", mem_writedata, e.data);
                end else begin
                    check("d_mem_read", {31'd0, mem_read}, 1);
                    check("d_readdata", d_readdata, e.data);
                end
            end
        end
        if (!RESET && grant[1] && i_read && !i_busywait) begin
            if (exp_i.size() == 0) check("i_unexpected_completion", 1, 0);
            else begin
                e = exp_i.pop_front();
                check("i_mem_address", {26'd0, mem_address}, {26'd0, e.addr});
                check("i_readdata", i_readdata, e.data);
            end
        end
    end

    logic [1:0] prev_grant = 2'b00;
    always @(negedge CLK) begin
        if (grant != prev_grant && grant != 2'b00) grant_log.push_back(grant);
        prev_grant <= grant;
    end

    task automatic d_do(input logic rd, input logic wr, input logic [5:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata);
        exp_t e;
        bit   done;
        d_read = rd; d_write = wr; d_address = addr; d_writedata = wdata;
        e.wr = wr; e.addr = addr; e.data = wr ? wdata : rdata;
        exp_d.push_back(e);
        done = 0;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge CLK);
            if (!d_busywait) done = 1;
        end
        if (!done) check("d_timeout", 0, 1);
        @(posedge CLK); #1;
        d_read = 1'b0; d_write = 1'b0;
    endtask

    task automatic i_issue(input logic [5:0] addr, input logic [31:0] rdata);
        exp_t e;
        i_read = 1'b1; i_address = addr;
        e.wr = 1'b0; e.addr = addr; e.data = rdata;
        exp_i.push_back(e);
    endtask

    task automatic i_finish();
        bit done;
        done = 0;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge CLK);
            if (!i_busywait) done = 1;
        end
        if (!done) check("i_timeout", 0, 1);
        @(posedge CLK); #1;
        i_read = 1'b0;
    endtask

    task automatic wait_grant(input logic [1:0] g, input string name);
        bit done;
        done = 0;
        for (int n = 0; n < 100 && !done; n++) begin
            @(negedge CLK);
            if (grant == g) done = 1;
        end
        if (!done) check(name, {30'd0, grant}, {30'd0, g});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        bit done;
        // Reset then idle
        #1 RESET = 1'b1;
        #3;
        check("rst_grant", {30'd0, grant}, 0);
        check("rst_mem_read", {31'd0, mem_read}, 0);
        check("rst_mem_write", {31'd0, mem_write}, 0);
        check("rst_mem_address", {26'd0, mem_address}, 0);
        check("rst_busywaits", {30'd0, d_busywait, i_busywait}, 0);
        #2 RESET = 1'b0;
        repeat (3) @(negedge CLK);
        check("idle_grant", {30'd0, grant}, 0);
        check("idle_mem_strobes", {30'd0, mem_read, mem_write}, 0);
        check("idle_busywaits", {30'd0, d_busywait, i_busywait}, 0);

        // Lone I read
        i_issue(6'h05, 32'hDEADBEEF);
        #1 check("i_busywait_same_cycle", {31'd0, i_busywait}, 1);
        @(negedge CLK);
        check("i_grant", {30'd0, grant}, 2'b10);
        check("i_addr_driven", {26'd0, mem_address}, 6'h05);
        check("i_mem_read", {31'd0, mem_read}, 1);
        i_finish();
        check("release_mem_read", {31'd0, mem_read}, 0);
        check("release_grant", {30'd0, grant}, 0);
        repeat (2) @(negedge CLK);

        // Simultaneous D write + I read: D first, one RELEASE cycle, then I
        fork
            d_do(1'b0, 1'b1, 6'h10, 32'h12345678, 32'h0);
            begin i_issue(6'h05, 32'hDEADBEEF); i_finish(); end
            begin
                wait_grant(2'b01, "sim_d_first");
                check("sim_i_held", {31'd0, i_busywait}, 1);
                check("sim_d_wdata", mem_writedata, 32'h12345678);
                done = 0;
                for (int n = 0; n < 100 && !done; n++) begin
                    @(negedge CLK);
                    if (grant != 2'b01) done = 1;
                end
                check("sim_release_gap", {30'd0, grant}, 0);
                @(negedge CLK);
                check("sim_i_after_d", {30'd0, grant}, 2'b10);
            end
        join
        repeat (2) @(negedge CLK);

        // Continuous contention, fixed priority: D keeps winning while it requests
        grant_log.delete();
        fork
            for (int k = 0; k < 4; k++)
                d_do(1'b1, 1'b0, 6'h20 + 6'(k), 32'h0, 32'hA5000020 + k);
            begin i_issue(6'h07, 32'hA5000007); i_finish(); end
        join
        repeat (2) @(negedge CLK);
        check("contention_log_len", grant_log.size(), 5);
        for (int k = 0; k < 5; k++)
            check($sformatf("contention_grant_%0d", k),
                  (k < grant_log.size()) ? {30'd0, grant_log[k]} : 32'hFFFF,
                  (k < 4) ? 32'd1 : 32'd2);

        // d_read and d_write both high: write wins
        fork
            d_do(1'b1, 1'b1, 6'h3F, 32'hCAFEF00D, 32'h0);
            begin
                wait_grant(2'b01, "rw_grant");
                check("rw_mem_write", {31'd0, mem_write}, 1);
                check("rw_mem_read", {31'd0, mem_read}, 0);
                check("rw_mem_address", {26'd0, mem_address}, 6'h3F);
            end
        join
        repeat (2) @(negedge CLK);

        // Reset two cycles into GNT_D, I pending
        d_write = 1'b1; d_address = 6'h11; d_writedata = 32'h00000055;
        i_read = 1'b1; i_address = 6'h09;
        @(negedge CLK);
        check("mid_grant_d", {30'd0, grant}, 2'b01);
        @(negedge CLK);
        @(negedge CLK);
        check("mid_mem_write_before", {31'd0, mem_write}, 1);
        #2 RESET = 1'b1;
        #1;
        check("mid_mem_write_async", {31'd0, mem_write}, 0);
        check("mid_grant_async", {30'd0, grant}, 0);
        check("mid_busywaits", {30'd0, d_busywait, i_busywait}, 0);
        d_write = 1'b0;
        #4 RESET = 1'b0;
        i_issue(6'h09, 32'hA5000009);
        i_finish();
        repeat (3) @(negedge CLK);

        check("exp_d_empty", exp_d.size(), 0);
        check("exp_i_empty", exp_i.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
